// File: rtl/multicycle_controller.sv
// Multi-cycle control unit: owns the instruction register and sequences each
// instruction through FETCH/DECODE/EXEC/MEM/WB using req/ack memory handshakes.
module multicycle_controller #(
    parameter int INSTR_W   = 16,
    parameter int OPC_W     = 4,
    parameter int ALU_CMD_W = 3,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INSTR_W-1:0]   imem_rdata,
    input  logic                 imem_ack,
    input  logic                 dmem_ack,
    input  logic                 zero,
    output logic                 imem_req,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [INSTR_W-1:0]   ir,
    output logic [ALU_CMD_W-1:0] alu_cmd,
    output logic                 alu_src_imm,
    output logic                 rf_wr_en,
    output logic                 wb_sel_mem,
    output logic                 pc_en,
    output logic [1:0]           pc_sel,
    output logic                 illegal,
    output logic [CNT_W-1:0]     retired,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [OPC_W-1:0] OP_NOP     = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_ALU_LO  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_ALU_HI  = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_LW      = OPC_W'(9);
    localparam logic [OPC_W-1:0] OP_SW      = OPC_W'(10);
    localparam logic [OPC_W-1:0] OP_BEQ     = OPC_W'(11);
    localparam logic [OPC_W-1:0] OP_JMP     = OPC_W'(12);

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    state_t               state_reg, state_next;
    logic [INSTR_W-1:0]   ir_reg;
    logic                 illegal_reg;
    logic [CNT_W-1:0]     retired_reg;

    logic [OPC_W-1:0]     opcode;
    logic                 is_nop, is_alu, is_lw, is_sw, is_beq, is_jmp, is_illegal;

    assign opcode     = ir_reg[INSTR_W-1 -: OPC_W];
    assign is_nop     = (opcode == OP_NOP);
    assign is_alu     = (opcode >= OP_ALU_LO) && (opcode <= OP_ALU_HI);
    assign is_lw      = (opcode == OP_LW);
    assign is_sw      = (opcode == OP_SW);
    assign is_beq     = (opcode == OP_BEQ);
    assign is_jmp     = (opcode == OP_JMP);
    assign is_illegal = (opcode > OP_JMP);

    // ALU command follows ir in every state, not only during EXEC.
    always_comb begin
        alu_cmd = {ALU_CMD_W{1'b1}};
        if (is_alu) begin
            alu_cmd = ALU_CMD_W'(opcode - OP_ALU_LO);
        end else if (is_lw || is_sw || is_beq) begin
            alu_cmd = '0;
        end
    end

    always_comb begin
        state_next  = state_reg;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        alu_src_imm = 1'b0;
        rf_wr_en    = 1'b0;
        wb_sel_mem  = 1'b0;
        pc_en       = 1'b0;
        pc_sel      = PC_NEXT;

        case (state_reg)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_alu || is_lw || is_sw || is_beq) begin
                    state_next = S_EXEC;
                end else begin
                    // NOP, JMP and illegal opcodes all retire here
                    pc_en      = 1'b1;
                    pc_sel     = is_jmp ? PC_JUMP : PC_NEXT;
                    state_next = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_imm = is_lw || is_sw;
                if (is_beq) begin
                    pc_en      = 1'b1;
                    pc_sel     = zero ? PC_BRANCH : PC_NEXT;
                    state_next = S_FETCH;
                end else if (is_alu) begin
                    state_next = S_WB;
                end else begin
                    state_next = S_MEM;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_sw;
                if (dmem_ack) begin
                    if (is_lw) begin
                        state_next = S_WB;
                    end else begin
                        pc_en      = 1'b1;
                        state_next = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_wr_en   = 1'b1;
                wb_sel_mem = is_lw;
                pc_en      = 1'b1;
                state_next = S_FETCH;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase

        // Keep every strobe quiet while reset is being applied.
        if (rst) begin
            state_next  = S_FETCH;
            imem_req    = 1'b0;
            dmem_req    = 1'b0;
            dmem_we     = 1'b0;
            alu_src_imm = 1'b0;
            rf_wr_en    = 1'b0;
            wb_sel_mem  = 1'b0;
            pc_en       = 1'b0;
            pc_sel      = PC_NEXT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_FETCH;
            ir_reg      <= '0;
            illegal_reg <= 1'b0;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_FETCH && imem_ack) begin
                ir_reg <= imem_rdata;
            end
            if (state_reg == S_DECODE && is_illegal) begin
                illegal_reg <= 1'b1;
            end
            if (pc_en) begin
                retired_reg <= retired_reg + CNT_W'(1);
            end
        end
    end

    assign ir      = ir_reg;
    assign illegal = illegal_reg;
    assign retired = retired_reg;
    assign busy    = (state_reg != S_FETCH);

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed and random instructions checked
// cycle by cycle against a per-instruction timing model derived from opcode rules.
module tb_multicycle_controller;

    localparam int INSTR_W   = 16;
    localparam int OPC_W     = 4;
    localparam int ALU_CMD_W = 3;
    localparam int CNT_W     = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [INSTR_W-1:0]   imem_rdata;
    logic                 imem_ack;
    logic                 dmem_ack;
    logic                 zero;
    logic                 imem_req;
    logic                 dmem_req;
    logic                 dmem_we;
    logic [INSTR_W-1:0]   ir;
    logic [ALU_CMD_W-1:0] alu_cmd;
    logic                 alu_src_imm;
    logic                 rf_wr_en;
    logic                 wb_sel_mem;
    logic                 pc_en;
    logic [1:0]           pc_sel;
    logic                 illegal;
    logic [CNT_W-1:0]     retired;
    logic                 busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [CNT_W-1:0] retired_model;
    logic             illegal_model;

    multicycle_controller #(
        .INSTR_W(INSTR_W), .OPC_W(OPC_W), .ALU_CMD_W(ALU_CMD_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .dmem_ack(dmem_ack), .zero(zero), .imem_req(imem_req), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .ir(ir), .alu_cmd(alu_cmd), .alu_src_imm(alu_src_imm),
        .rf_wr_en(rf_wr_en), .wb_sel_mem(wb_sel_mem), .pc_en(pc_en), .pc_sel(pc_sel),
        .illegal(illegal), .retired(retired), .busy(busy)
    );

    always #5 clk = ~clk;

    // Zero-wait latency in cycles for each opcode class.
    function automatic int base_latency(input logic [3:0] op);
        if (op == 4'd0 || op >= 4'd12) return 2;
        if (op <= 4'd8)                return 4;
        if (op == 4'd9)                return 5;
        if (op == 4'd10)               return 4;
        return 3;
    endfunction

    function automatic logic [2:0] exp_alu_cmd(input logic [3:0] op);
        if (op >= 4'd1 && op <= 4'd8)  return 3'(op - 4'd1);
        if (op >= 4'd9 && op <= 4'd11) return 3'd0;
        return 3'd7;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drives one instruction from FETCH to its retirement, checking every cycle.
    task automatic run_instr(input logic [15:0] instr, input int iw, input int dw, input logic z);
        logic [3:0] op;
        logic       is_mem, writes;
        int         last, mem_start;
        logic [7:0] obs_v, exp_v;
        logic [1:0] exp_sel;
        op        = instr[15:12];
        is_mem    = (op == 4'd9) || (op == 4'd10);
        writes    = (op >= 4'd1 && op <= 4'd8) || (op == 4'd9);
        mem_start = iw + 3;
        last      = base_latency(op) - 1 + iw + (is_mem ? dw : 0);
        if (op == 4'd12)                exp_sel = 2'b10;
        else if (op == 4'd11 && z)      exp_sel = 2'b01;
        else                            exp_sel = 2'b00;
        for (int k = 0; k <= last; k++) begin
            imem_rdata = instr;
            imem_ack   = (k >= iw);
            dmem_ack   = (k >= mem_start + dw);
            zero       = z;
            @(negedge clk);
            obs_v = {imem_req, busy, dmem_req, dmem_we, rf_wr_en, wb_sel_mem, alu_src_imm, pc_en};
            exp_v[7] = (k <= iw);
            exp_v[6] = (k > iw);
            exp_v[5] = is_mem && (k >= mem_start) && (k <= mem_start + dw);
            exp_v[4] = exp_v[5] && (op == 4'd10);
            exp_v[3] = writes && (k == last);
            exp_v[2] = (op == 4'd9) && (k == last);
            exp_v[1] = is_mem && (k == iw + 2);
            exp_v[0] = (k == last);
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL strobes instr=%h cycle=%0d got=%b want=%b", instr, k, obs_v, exp_v);
            end
            if (k > iw) begin
                n_cmp++;
                if (alu_cmd !== exp_alu_cmd(op)) begin
                    n_fail++;
                    $display("FAIL alu_cmd instr=%h cycle=%0d got=%b want=%b", instr, k, alu_cmd, exp_alu_cmd(op));
                end
            end
            if (k == last) begin
                n_cmp++;
                if (pc_sel !== exp_sel) begin
                    n_fail++;
                    $display("FAIL pc_sel instr=%h got=%b want=%b", instr, pc_sel, exp_sel);
                end
            end
            next_cycle();
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        if (op >= 4'd13) illegal_model = 1'b1;
        retired_model = retired_model + 4'd1;
        n_cmp++;
        if ({ir, illegal, retired, busy} !== {instr, illegal_model, retired_model, 1'b0}) begin
            n_fail++;
            $display("FAIL retire instr=%h got ir=%h ill=%b ret=%0d busy=%b want ir=%h ill=%b ret=%0d busy=0",
                     instr, ir, illegal, retired, busy, instr, illegal_model, retired_model);
        end
        $display("txn instr=%h iw=%0d dw=%0d zero=%b cycles=%0d retired=%0d", instr, iw, dw, z, last + 1, retired);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        retired_model = '0;
        illegal_model = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1; imem_rdata = 16'h1234; zero = 1'b0;
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if ({imem_req, dmem_req, dmem_we, rf_wr_en, pc_en} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes got=%b want=00000", {imem_req, dmem_req, dmem_we, rf_wr_en, pc_en});
        end
        @(posedge clk); #1;
        rst = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        retired_model = '0;
        illegal_model = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ir, illegal, retired, busy, imem_req, alu_cmd} !== {16'h0, 1'b0, 4'h0, 1'b0, 1'b1, 3'b111}) begin
            n_fail++;
            $display("FAIL reset_state got ir=%h ill=%b ret=%0d busy=%b ireq=%b cmd=%b want 0000/0/0/0/1/111",
                     ir, illegal, retired, busy, imem_req, alu_cmd);
        end
        $display("txn reset");
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        run_instr(16'h2345, 0, 0, 1'b0);
        run_instr(16'h8fff, 1, 0, 1'b1);
    endtask

    task automatic test_lw();
        run_instr(16'h9ABC, 0, 3, 1'b0);
    endtask

    task automatic test_sw();
        run_instr(16'hA123, 0, 0, 1'b0);
        run_instr(16'hA123, 2, 1, 1'b1);
    endtask

    task automatic test_branch_jump();
        run_instr(16'hB000, 0, 0, 1'b1);
        run_instr(16'hB000, 0, 0, 1'b0);
        run_instr(16'hC000, 0, 0, 1'b1);
    endtask

    task automatic test_illegal();
        run_instr(16'hE000, 0, 0, 1'b0);
        run_instr(16'h1000, 0, 0, 1'b0);
        run_instr(16'h0000, 1, 0, 1'b0);
    endtask

    task automatic test_reset_mid_mem();
        int guard;
        imem_rdata = 16'h9ABC; imem_ack = 1'b1; dmem_ack = 1'b0; zero = 1'b0;
        guard = 0;
        @(negedge clk);
        while (dmem_req !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            imem_ack = 1'b0;
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (dmem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL reach_mem got dmem_req=%b want=1", dmem_req);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({dmem_req, pc_en, rf_wr_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL mem_rst_strobes got=%b want=000", {dmem_req, pc_en, rf_wr_en});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        dmem_ack = 1'b1;
        retired_model = '0;
        illegal_model = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, dmem_req, imem_req, ir, retired} !== {1'b0, 1'b0, 1'b1, 16'h0, 4'h0}) begin
                n_fail++;
                $display("FAIL after_mem_rst cycle=%0d got busy=%b dreq=%b ireq=%b ir=%h ret=%0d want 0/0/1/0000/0",
                         k, busy, dmem_req, imem_req, ir, retired);
            end
            @(posedge clk); #1;
        end
        dmem_ack = 1'b0;
        $display("txn reset_in_mem");
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 17; i++) run_instr(16'h0000, 0, 0, 1'b0);
        n_cmp++;
        if (retired !== 4'd1) begin
            n_fail++;
            $display("FAIL wrap got=%0d want=1", retired);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] instr;
        for (int i = 0; i < 40; i++) begin
            instr = 16'($urandom);
            run_instr(instr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
        end
    endtask

    initial begin
        rst = 1'b1; imem_rdata = '0; imem_ack = 1'b0; dmem_ack = 1'b0; zero = 1'b0;
        retired_model = '0;
        illegal_model = 1'b0;
        #1;
        test_reset();
        test_alu();
        test_lw();
        test_sw();
        test_branch_jump();
        test_illegal();
        test_reset_mid_mem();
        test_wrap();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
